// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial loader slice.
//   ST_IDLE / ST_SHIFT / ST_PAR : FSM state encodings (2-bit, legacy-compatible)
//   cnt_w(width)                : bit-counter width able to hold 0..width
package serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// bit_counter: frame bit index counter with load, enable and terminal flag.
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   load     in   restart the count at 0 (wins over en)
//   en       in   advance by one; holds at the terminal value, never wraps
//   count    out  current bit index, 0..WIDTH-1
//   terminal out  count == WIDTH-1
module bit_counter
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  assign terminal = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !terminal) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out loader feeding a serial shift register.
// Accepts a WIDTH-bit word over valid/ready and emits one bit per clk on sout,
// framed by sout_valid / sout_last. Back-to-back words run gaplessly.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   din        in   parallel word, sampled when din_valid && din_ready
//   din_valid  in   upstream word available
//   din_ready  out  word can be accepted this cycle (combinational from state)
//   sout       out  registered serial bit
//   sout_valid out  sout carries a frame bit
//   sout_last  out  sout is the final bit of the frame
// Build option: define PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

  localparam int unsigned CW = cnt_w(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic             sout_q;
  logic [CW-1:0]    count;
  logic             terminal;
  logic             last_data;
  logic             accept;
  logic [WIDTH-1:0] shifted;
`ifdef PARITY_EN
  logic             par_q;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // sreg always holds the bit currently on sout in its output position,
  // so the next bit is simply the output position of the shifted word.
  always_comb begin
    shifted = '0;
    if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, sreg[WIDTH-1:1]};
  end

  assign last_data  = (state == ST_SHIFT) && terminal;
  assign sout_valid = (state != ST_IDLE);
  assign sout       = sout_q;

`ifdef PARITY_EN
  assign din_ready = !rst && ((state == ST_IDLE) || (state == ST_PAR));
  assign sout_last = (state == ST_PAR);
`else
  assign din_ready = !rst && ((state == ST_IDLE) || last_data);
  assign sout_last = last_data;
`endif

  assign accept = din_valid && din_ready;

  bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (state == ST_SHIFT),
    .count    (count),
    .terminal (terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      sreg   <= '0;
      sout_q <= 1'b0;
`ifdef PARITY_EN
      par_q  <= 1'b0;
`endif
    end else if (accept) begin
      // accept is only possible in IDLE or on the frame's final bit, so a
      // reload here covers both the first word and the gapless follow-on.
      state  <= ST_SHIFT;
      sreg   <= din;
      sout_q <= first_bit(din);
`ifdef PARITY_EN
      par_q  <= ^din;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          sout_q <= 1'b0;
        end
        ST_SHIFT: begin
          if (!terminal) begin
            sreg   <= shifted;
            sout_q <= first_bit(shifted);
          end else begin
`ifdef PARITY_EN
            state  <= ST_PAR;
            sreg   <= '0;
            sout_q <= par_q;
`else
            state  <= ST_IDLE;
            sreg   <= '0;
            sout_q <= 1'b0;
`endif
          end
        end
        default: begin
          state  <= ST_IDLE;
          sreg   <= '0;
          sout_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer, WIDTH=4, one MSB-first
// and one LSB-first instance driven by the same stimulus. Honours PARITY_EN.
module tb_piso_serializer;

`ifdef PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       rdy0, rdy1, s0, s1, v0, v1, l0, l1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy0), .sout(s0), .sout_valid(v0), .sout_last(l0)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy1), .sout(s1), .sout_valid(v1), .sout_last(l1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!(rdy0 && rdy1) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!(rdy0 && rdy1)) begin
      errors++;
      $display("FAIL %s ready timeout got %b%b want 11", nm, rdy0, rdy1);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({rdy0, rdy1, s0, s1, v0, v1, l0, l1} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000", {rdy0, rdy1, s0, s1, v0, v1, l0, l1});
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({rdy0, rdy1, v0, v1, s0, s1, l0, l1} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_release got %b want 11000000", {rdy0, rdy1, v0, v1, s0, s1, l0, l1});
    end
  endtask

  task automatic test_bit_order();
    logic [9:0] e0, e1;
    logic       lst;
`ifdef PARITY_EN
    e0 = 10'b10111; e1 = 10'b11011;
`else
    e0 = 10'b1011;  e1 = 10'b1101;
`endif
    wait_ready("bit_order");
    din = 4'b1011; din_valid = 1'b1;
    step();
    din_valid = 1'b0; din = '0;
    for (int i = 0; i < FRAME; i++) begin
      lst = (i == FRAME - 1);
      checks++;
      if ({v0, v1, s0, s1, l0, l1, rdy0} !== {2'b11, e0[FRAME-1-i], e1[FRAME-1-i], lst, lst, lst}) begin
        errors++;
        $display("FAIL bit_order cycle %0d got v%b%b s%b%b l%b%b r%b want v11 s%b%b l%b%b r%b",
                 i, v0, v1, s0, s1, l0, l1, rdy0, e0[FRAME-1-i], e1[FRAME-1-i], lst, lst, lst);
      end
      if (i < FRAME - 1) step();
    end
    step();
    checks++;
    if ({v0, v1, s0, s1, l0, l1, rdy0} !== 7'b0000001) begin
      errors++;
      $display("FAIL bit_order_idle got %b want 0000001", {v0, v1, s0, s1, l0, l1, rdy0});
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] e0, e1;
    logic        lst;
`ifdef PARITY_EN
    e0 = 20'b1010001010; e1 = 20'b0101010100;
`else
    e0 = 20'b10100101;   e1 = 20'b01011010;
`endif
    wait_ready("back_to_back");
    din = 4'hA; din_valid = 1'b1;
    step();
    din = 4'h5;
    for (int i = 0; i < 2 * FRAME; i++) begin
      lst = ((i % FRAME) == FRAME - 1);
      checks++;
      if ({v0, v1, s0, s1, l0, l1, rdy0} !== {2'b11, e0[2*FRAME-1-i], e1[2*FRAME-1-i], lst, lst, lst}) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got v%b%b s%b%b l%b%b r%b want v11 s%b%b l%b%b r%b",
                 i, v0, v1, s0, s1, l0, l1, rdy0, e0[2*FRAME-1-i], e1[2*FRAME-1-i], lst, lst, lst);
      end
      if (i == FRAME) din_valid = 1'b0;
      if (i < 2 * FRAME - 1) step();
    end
    step();
    checks++;
    if ({v0, v1, l0, l1, rdy0} !== 5'b00001) begin
      errors++;
      $display("FAIL back_to_back_idle got %b want 00001", {v0, v1, l0, l1, rdy0});
    end
  endtask

  task automatic test_parity();
    logic [9:0] e0, e1;
    logic       lst;
`ifdef PARITY_EN
    e0 = 10'b00110; e1 = 10'b11000;
`else
    e0 = 10'b0011;  e1 = 10'b1100;
`endif
    wait_ready("parity");
    din = 4'b0011; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      lst = (i == FRAME - 1);
      checks++;
      if ({v0, v1, s0, s1, l0, l1} !== {2'b11, e0[FRAME-1-i], e1[FRAME-1-i], lst, lst}) begin
        errors++;
        $display("FAIL parity cycle %0d got v%b%b s%b%b l%b%b want v11 s%b%b l%b%b",
                 i, v0, v1, s0, s1, l0, l1, e0[FRAME-1-i], e1[FRAME-1-i], lst, lst);
      end
      if (i < FRAME - 1) step();
    end
    step();
  endtask

  task automatic test_busy_ignore();
    logic [9:0] e0, e1;
    logic       lst;
`ifdef PARITY_EN
    e0 = 10'b10111; e1 = 10'b11011;
`else
    e0 = 10'b1011;  e1 = 10'b1101;
`endif
    wait_ready("busy_ignore");
    din = 4'b1011; din_valid = 1'b1;
    step();
    din = 4'hF;
    for (int i = 0; i < FRAME; i++) begin
      din_valid = (i != FRAME - 1) && ((i % 2) == 0);
      lst = (i == FRAME - 1);
      checks++;
      if ({v0, v1, s0, s1, l0, l1, rdy0} !== {2'b11, e0[FRAME-1-i], e1[FRAME-1-i], lst, lst, lst}) begin
        errors++;
        $display("FAIL busy_ignore cycle %0d got v%b%b s%b%b l%b%b r%b want v11 s%b%b l%b%b r%b",
                 i, v0, v1, s0, s1, l0, l1, rdy0, e0[FRAME-1-i], e1[FRAME-1-i], lst, lst, lst);
      end
      if (i < FRAME - 1) step();
    end
    din_valid = 1'b0;
    step();
    checks++;
    if ({v0, v1, s0, s1} !== 4'b0000) begin
      errors++;
      $display("FAIL busy_ignore_idle got %b want 0000", {v0, v1, s0, s1});
    end
  endtask

  task automatic test_reset_mid_frame();
    wait_ready("reset_mid_frame");
    din = 4'b1011; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    checks++;
    if ({v0, s0, s1} !== 3'b111) begin
      errors++;
      $display("FAIL mid_frame_bit0 got %b want 111", {v0, s0, s1});
    end
    step();
    checks++;
    if ({v0, s0, s1} !== 3'b101) begin
      errors++;
      $display("FAIL mid_frame_bit1 got %b want 101", {v0, s0, s1});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rdy0, rdy1, s0, s1, v0, v1, l0, l1} !== 8'b0) begin
      errors++;
      $display("FAIL mid_frame_reset got %b want 00000000", {rdy0, rdy1, s0, s1, v0, v1, l0, l1});
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({rdy0, rdy1, v0, v1, s0, s1} !== 6'b110000) begin
      errors++;
      $display("FAIL mid_frame_release got %b want 110000", {rdy0, rdy1, v0, v1, s0, s1});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({v0, v1, s0, s1, l0, l1} !== 6'b0) begin
        errors++;
        $display("FAIL mid_frame_no_resume cycle %0d got %b want 000000", i, {v0, v1, s0, s1, l0, l1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_back_to_back();
    test_parity();
    test_busy_ignore();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
